// File: rtl/spi_reg_bank_if.sv
// SPI pad-side signals of the register bank. The controller (pads/testbench) drives
// sclk/copi/ncs; the register bank drives cipo and its output enable.
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W control registers, with read-back
// and optional burst auto-increment. All SPI pins are asynchronous to clk.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // ncs idles high, so its chain resets to 1 to avoid a phantom frame start.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
  logic                   r_sclk_d, r_ncs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_ncs, w_copi;
  logic w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk &  r_sclk_d;
  assign w_ncs_rise  =  w_ncs  & ~r_ncs_d;
  assign w_ncs_fall  = ~w_ncs  &  r_ncs_d;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic                r_rw, w_rw_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_cipo, w_cipo_nxt;
  logic                r_cipo_oe, w_cipo_oe_nxt;
  logic                r_frame_err, w_frame_err_nxt;
  logic                r_wr_valid, w_wr_valid_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [ADDR_W-1:0]   w_addr_shift, w_addr_inc, w_rd_addr;
  logic [DATA_W-1:0]   w_rd_word, w_wr_word;

  assign w_addr_shift = {r_addr[ADDR_W-2:0], w_copi};
  assign w_addr_inc   = (r_addr == '1) ? r_addr : r_addr + ADDR_W'(1);
  assign w_rd_addr    = (r_state == S_ADDR) ? w_addr_shift : w_addr_inc;
  assign w_wr_word    = {r_shift[DATA_W-2:0], w_copi};

  // Unimplemented addresses read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (32'(w_rd_addr) == r) w_rd_word = r_regs[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_cipo      <= 1'b0;
      r_cipo_oe   <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rw        <= w_rw_nxt;
      r_addr      <= w_addr_nxt;
      r_shift     <= w_shift_nxt;
      r_cipo      <= w_cipo_nxt;
      r_cipo_oe   <= w_cipo_oe_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_wr_valid  <= w_wr_valid_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path leaves a latch behind.
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_rw_nxt        = r_rw;
    w_addr_nxt      = r_addr;
    w_shift_nxt     = r_shift;
    w_cipo_nxt      = r_cipo;
    w_cipo_oe_nxt   = r_cipo_oe;
    w_frame_err_nxt = 1'b0;
    w_wr_valid_nxt  = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;

    if (w_ncs_rise) begin
      // Deselect beats any sclk edge seen in the same cycle.
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = '0;
      w_cipo_nxt    = 1'b0;
      w_cipo_oe_nxt = 1'b0;
      if (r_state == S_CMD || r_state == S_ADDR || (r_state == S_DATA && r_bit_cnt != '0))
        w_frame_err_nxt = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_ncs_fall) begin
            w_state_nxt   = S_CMD;
            w_bit_cnt_nxt = '0;
          end
        end
        S_CMD: begin
          if (w_sclk_rise && !w_ncs) begin
            w_rw_nxt      = w_copi;
            w_bit_cnt_nxt = '0;
            w_state_nxt   = S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_sclk_rise && !w_ncs) begin
            w_addr_nxt = w_addr_shift;
            if (r_bit_cnt == ADDR_LAST) begin
              w_bit_cnt_nxt = '0;
              w_state_nxt   = S_DATA;
              if (!r_rw) begin
                w_shift_nxt   = w_rd_word;
                w_cipo_nxt    = w_rd_word[DATA_W-1];
                w_cipo_oe_nxt = 1'b1;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (w_sclk_rise && !w_ncs) begin
            if (r_rw) w_shift_nxt = w_wr_word;
            if (r_bit_cnt == DATA_LAST) begin
              w_bit_cnt_nxt = '0;
              if (r_rw && in_range(r_addr)) begin
                w_wr_valid_nxt = 1'b1;
                w_wr_addr_nxt  = r_addr;
                w_wr_data_nxt  = w_wr_word;
              end
              if (BURST_EN != 0) begin
                w_addr_nxt = w_addr_inc;
                if (!r_rw) begin
                  w_shift_nxt = w_rd_word;
                  w_cipo_nxt  = w_rd_word[DATA_W-1];
                end
              end else begin
                w_state_nxt   = S_DONE;
                w_cipo_nxt    = 1'b0;
                w_cipo_oe_nxt = 1'b0;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end else if (w_sclk_fall && !r_rw && r_bit_cnt != '0) begin
            // A fall right after a word boundary keeps the freshly loaded MSB.
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            w_cipo_nxt  = r_shift[DATA_W-2];
          end
        end
        S_DONE: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset because consumers must see a defined configuration.
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
      wr_strobe <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        wr_strobe[r] <= r_wr_valid && (32'(r_wr_addr) == r);
        if (r_wr_valid && (32'(r_wr_addr) == r)) r_regs[r] <= r_wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign frame_err   = r_frame_err;
  assign spi.cipo    = r_cipo;
  assign spi.cipo_oe = r_cipo_oe;

endmodule
